// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive/transmit state
//               machines: default frame geometry and the receiver state set.
//               The transmitter imports the same package, so both ends of the
//               link agree on the defaults.
// Contents    : DEF_DATA_WIDTH, DEF_CLKS_PER_BIT, uart_rx_state_e
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default frame geometry (8N1, 16x oversampling)
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  // Receiver states. The encoding is fixed so that RTL using plain
  // logic [2:0] constants stays compatible with older code.
  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,  // wait for the line to be seen idle (high)
    ST_IDLE      = 3'd1,  // line idle, looking for a start edge
    ST_START     = 3'd2,  // timing to the middle of the start bit
    ST_DATA      = 3'd3,  // sampling data bits at mid-bit
    ST_STOP      = 3'd4   // timing to the middle of the stop bit
  } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_state_machine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_state_machine_if
// Description : Consumer-side bus of the UART receiver: received byte with a
//               valid/ready handshake plus status outputs.
// Signals     : data        received byte, stable while data_valid=1
//               data_valid  byte available, held until consumed
//               data_ready  consumer accepts on a clk edge with valid&ready
//               busy        receiver not in IDLE
//               frame_err   1-cycle pulse, stop bit sampled low
//               overrun     1-cycle pulse, frame completed while holding full
// Modports    : master - the receiver; slave - the byte consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_state_machine_if #(
  parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output data,
    output data_valid,
    input  data_ready,
    output busy,
    output frame_err,
    output overrun
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready,
    input  busy,
    input  frame_err,
    input  overrun
  );

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter with a zero flag, used for bit timing
//               by both the UART receiver and transmitter. A load takes
//               priority over counting; when enabled the count decrements
//               and holds at zero until reloaded.
// Ports       : clk       system clock
//               rst       asynchronous reset, active low
//               load      load load_val on the next edge
//               load_val  value to load
//               en        decrement enable
//               zero      count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_state_machine.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_state_machine
// Description : 8N1 UART receiver. Synchronises rxd, times each bit with
//               CLKS_PER_BIT clocks (CLKS_PER_BIT >= 4, even), samples at
//               mid-bit, checks start and stop bits and delivers each byte
//               through a one-entry holding register on a valid/ready
//               handshake. Reports framing errors and overruns as pulses.
// Ports       : clk   system clock
//               rst   asynchronous reset, active low (0 = reset)
//               rxd   serial input, idle high, asynchronous to clk
//               bus   consumer bus (data/valid/ready, busy, frame_err,
//                     overrun), master side
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_state_machine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rxd,
  uart_rx_state_machine_if.master        bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  // Half a bit minus one lands the first sample in the middle of the start
  // bit; every later sample is one full bit period further on.
  localparam logic [CNT_W-1:0] c_half_load = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_load = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] c_wait_idle = ST_WAIT_IDLE;
  localparam logic [2:0] c_idle      = ST_IDLE;
  localparam logic [2:0] c_start     = ST_START;
  localparam logic [2:0] c_data      = ST_DATA;
  localparam logic [2:0] c_stop      = ST_STOP;

  // --------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle level so that reset
  // release never looks like a start edge.
  // --------------------------------------------------------------------------
  logic r_rxd_meta;
  logic r_rxd_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Bit timer
  // --------------------------------------------------------------------------
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_load_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;

  uart_bit_timer #(
    .WIDTH (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_load_val),
    .en       (w_tmr_en),
    .zero     (w_tmr_zero)
  );

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] r_bit_idx;

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = c_full_load;
    case (r_state)
      c_wait_idle: begin
        // A line stuck low (or a bad stop bit) must go high before any
        // falling edge can be trusted as a start bit.
        if (r_rxd_s) begin
          w_state_nxt = c_idle;
        end
      end
      c_idle: begin
        if (!r_rxd_s) begin
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_half_load;
          w_state_nxt    = c_start;
        end
      end
      c_start: begin
        if (w_tmr_zero) begin
          if (r_rxd_s) begin
            // Line back high by mid start bit: treat as a glitch.
            w_state_nxt = c_idle;
          end else begin
            w_tmr_load  = 1'b1;
            w_state_nxt = c_data;
          end
        end
      end
      c_data: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          if (r_bit_idx == c_last_idx) begin
            w_state_nxt = c_stop;
          end
        end
      end
      c_stop: begin
        if (w_tmr_zero) begin
          w_state_nxt = r_rxd_s ? c_idle : c_wait_idle;
        end
      end
      default: begin
        w_state_nxt = c_wait_idle;
      end
    endcase
  end

  assign w_tmr_en = (r_state == c_start) || (r_state == c_data) ||
                    (r_state == c_stop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_wait_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample strobes
  logic w_start_ok;
  logic w_data_sample;
  logic w_stop_sample;
  logic w_commit;
  logic w_stop_bad;

  assign w_start_ok    = (r_state == c_start) && w_tmr_zero && !r_rxd_s;
  assign w_data_sample = (r_state == c_data)  && w_tmr_zero;
  assign w_stop_sample = (r_state == c_stop)  && w_tmr_zero;
  assign w_commit      = w_stop_sample &&  r_rxd_s;
  assign w_stop_bad    = w_stop_sample && !r_rxd_s;

  // --------------------------------------------------------------------------
  // Bit index and shift register. Bits enter at the MSB and move down, so
  // after DATA_WIDTH samples the first (LSB-first) bit sits in bit 0.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_idx <= '0;
      r_shreg   <= '0;
    end else begin
      if (w_start_ok) begin
        r_bit_idx <= '0;
      end else if (w_data_sample) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_data_sample) begin
        r_shreg <= {r_rxd_s, r_shreg[DATA_WIDTH-1:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Holding register, handshake and status pulses. A commit is accepted when
  // the register is empty or is being consumed on the same edge; otherwise
  // the new byte is dropped and the held byte is kept.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  w_consume;

  assign w_consume = r_data_valid && bus.data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_commit) begin
        if (!r_data_valid || w_consume) begin
          r_data       <= r_shreg;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = (r_state != c_idle);
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_state_machine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_state_machine
// Description : Self-checking bench for uart_rx_state_machine. A behavioural
//               UART transmitter drives rxd; a frame-level model predicts the
//               delivered bytes, frame errors and overruns, and a monitor
//               collects what the receiver actually produced.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_state_machine;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  always #5 clk = ~clk;

  uart_rx_state_machine_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_state_machine #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  // Check bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: what the receiver produced
  logic [7:0] got_q[$];
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int vhi_cnt   = 0;
  int busy_gap  = 0;
  bit mid_frame = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data);
      if (bus.data_valid) vhi_cnt++;
      if (bus.frame_err)  fe_cnt++;
      if (bus.overrun)    ov_cnt++;
      if (mid_frame && !bus.busy) busy_gap++;
    end
  end

  // Frame-level reference model: one holding slot, bytes leave when ready.
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  int         exp_ov = 0;
  bit         m_held = 1'b0;
  logic [7:0] m_byte = '0;

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                exp_fe++;
    else if (m_held)             exp_ov++;
    else if (bus.data_ready)     exp_q.push_back(b);
    else begin
      m_held = 1'b1;
      m_byte = b;
    end
  endtask

  task automatic model_release();
    bus.data_ready = 1'b1;
    if (m_held) begin
      exp_q.push_back(m_byte);
      m_held = 1'b0;
    end
  endtask

  task automatic scoreboard(input string tag);
    check({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, " byte"}, got_q[i], exp_q[i]);
    check({tag, " frame_err pulses"}, fe_cnt, exp_fe);
    check({tag, " overrun pulses"}, ov_cnt, exp_ov);
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0; ov_cnt = 0; exp_fe = 0; exp_ov = 0;
    vhi_cnt = 0; busy_gap = 0;
  endtask

  // Behavioural transmitter
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    mid_frame = 1'b1;
    for (int i = 0; i < DW; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(4);
    mid_frame = 1'b0;
    tick(CPB - 4);
    rxd = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data"},       bus.data,       8'h00);
    check({tag, " data_valid"}, bus.data_valid, 1'b0);
    check({tag, " frame_err"},  bus.frame_err,  1'b0);
    check({tag, " overrun"},    bus.overrun,    1'b0);
    check({tag, " busy"},       bus.busy,       1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b;
    bit         ok;

    bus.data_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(4);

    // 1: single frame, consumer always ready
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1);
    tick(10);
    check("t1 valid width", vhi_cnt, 1);
    scoreboard("t1");

    // 2: back-to-back frames; idle only between them
    model_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    @(negedge clk);
    check("t2 idle between frames", bus.busy, 1'b0);
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(10);
    check("t2 busy inside frames", busy_gap, 0);
    scoreboard("t2");

    // 3: short low glitch is rejected
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(12);
    @(negedge clk);
    check("t3 idle after glitch", bus.busy, 1'b0);
    tick(20);
    scoreboard("t3");

    // 4: bad stop bit, then recovery
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    rxd = 1'b1;
    tick(2 * CPB);
    model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1);
    tick(10);
    scoreboard("t4");

    // 5: holding register full -> overrun on the second frame
    bus.data_ready = 1'b0;
    model_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(10);
    @(negedge clk);
    check("t5 held data", bus.data, m_byte);
    check("t5 held valid", bus.data_valid, 1'b1);
    tick(1);
    model_release();
    @(negedge clk);
    @(negedge clk);
    check("t5 valid falls", bus.data_valid, 1'b0);
    tick(5);
    scoreboard("t5");

    // 6: asynchronous reset during data bit 3
    b = 8'h81;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = b[3];
    tick(CPB / 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6 in reset");
    rxd = 1'b1;
    tick(5);
    @(negedge clk);
    rst = 1'b1;
    m_held = 1'b0;
    tick(4);
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(10);
    scoreboard("t6");

    // Randomised frames, gaps and stop-bit errors
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      model_frame(b, ok);
      send_frame(b, ok);
      if (!ok) tick(2 * CPB + int'($urandom_range(0, 8)));
      else     tick(int'($urandom_range(0, 20)));
    end
    tick(10);
    check("rand busy inside frames", busy_gap, 0);
    scoreboard("rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
